// File: rtl/fft_pkg.sv
// Shared definitions for the FFT reorder datapath: default sizes, the complex
// sample layout and a generic index bit-reversal helper.
package fft_pkg;

  localparam int NUM_POINTS_DEFAULT = 64;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic signed [DATA_WIDTH_DEFAULT/2-1:0] i;
    logic signed [DATA_WIDTH_DEFAULT/2-1:0] q;
  } cplx_t;

  // Reverses the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < width) r[b] = value[5'(width - 1 - b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of reorder storage: a write port, a combinational read port and
// the per-bank full flag and reorder mode bit.
module reorder_bank #(
  parameter int NUM_POINTS = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  set_full,
  input  logic                  clr_full,
  input  logic                  mode_load,
  input  logic                  mode_in,
  output logic                  full,
  output logic                  mode
);

  logic [DATA_WIDTH-1:0] mem [NUM_POINTS];

  // Sample storage is deliberately left out of reset; full gates every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= 1'b0;
      mode <= 1'b0;
    end else begin
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
      if (mode_load)     mode <= mode_in;
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: frames are written in natural order
// (scattered to bit-reversed addresses when requested) and read out linearly.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter  int NUM_POINTS = NUM_POINTS_DEFAULT,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  localparam int IDX_WIDTH  = $clog2(NUM_POINTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_reverse,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  out_last
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_POINTS - 1);

  logic                  wr_bank;
  logic                  rd_bank;
  logic [IDX_WIDTH-1:0]  wr_cnt;
  logic [IDX_WIDTH-1:0]  rd_cnt;
  logic [1:0]            full;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] rdata [2];

  logic                  accept;
  logic                  rd_fire;
  logic                  wr_last;
  logic                  rd_last;
  logic                  wr_first;
  logic                  mode_now;
  logic [IDX_WIDTH-1:0]  waddr;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_last   = (wr_cnt == LAST_IDX);
  assign rd_last   = (rd_cnt == LAST_IDX);
  assign wr_first  = (wr_cnt == '0);

  // The first sample of a frame must use the mode being latched that same cycle.
  assign mode_now = wr_first ? in_reverse : mode[wr_bank];
  assign waddr    = mode_now ? IDX_WIDTH'(bitrev(32'(wr_cnt), IDX_WIDTH)) : wr_cnt;

  assign out_data  = rdata[rd_bank];
  assign out_index = rd_cnt;
  assign out_last  = out_valid && rd_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (accept) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt <= rd_cnt + IDX_WIDTH'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .NUM_POINTS (NUM_POINTS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .we        (accept && (wr_bank == 1'(b))),
      .waddr     (waddr),
      .wdata     (in_data),
      .raddr     (rd_cnt),
      .rdata     (rdata[b]),
      .set_full  (accept && wr_last && (wr_bank == 1'(b))),
      .clr_full  (rd_fire && rd_last && (rd_bank == 1'(b))),
      .mode_load (accept && wr_first && (wr_bank == 1'(b))),
      .mode_in   (in_reverse),
      .full      (full[b]),
      .mode      (mode[b])
    );
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Streaming bit-reversal reorder buffer for the MIMO-OFDM FFT/IFFT datapath.
- Accepts one complex sample per cycle in natural order and emits each NUM_POINTS-sample frame in bit-reversed order, or in natural order when reversal is disabled for that frame.
- Ping-pong double buffering sustains full throughput.
- Sits between the FFT core output and the subcarrier demapper, with valid/ready on both sides.

Parameters:
- NUM_POINTS, 64, frame length; power of two, at least 4.
- DATA_WIDTH, 32, sample width (packed I/Q).
- IDX_WIDTH, $clog2(NUM_POINTS), index width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous active-low reset; asserted when 0, sampled on the rising edge of clk.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_data  in  DATA_WIDTH  input sample, natural order.
- in_reverse  in  1  reorder mode for the frame; sampled with the frame's first sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DATA_WIDTH  reordered sample.
- out_index  out  IDX_WIDTH  output position within the frame (0..NUM_POINTS-1).
- out_last  out  1  high with the final sample of the frame.

Behaviour:
- Storage:
  - Two banks, each NUM_POINTS x DATA_WIDTH flops.
  - Per bank: a full flag and a mode bit.
  - Write pointer wr_bank/wr_cnt; read pointer rd_bank/rd_cnt.
- Reset (reset==0 at an edge):
  - Clear wr_bank, rd_bank, wr_cnt, rd_cnt, both full flags and both mode bits.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_last=0, out_index=0, out_data=don't care.
  - Bank contents are not cleared.
  - Reset mid-frame discards partial and full frames; the next accepted input is sample 0 of a new frame.
- Write side:
  - in_ready = !full[wr_bank].
  - Accept on in_valid && in_ready.
  - On an accept with wr_cnt==0, latch in_reverse into mode[wr_bank].
  - Write address = bitrev(wr_cnt) if the frame's mode is 1, else wr_cnt.
  - The mode applied is the value being latched on that same cycle.
  - wr_cnt increments on each accept.
  - On accepting wr_cnt==NUM_POINTS-1: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_cnt]; out_index = rd_cnt; out_last = out_valid && rd_cnt==NUM_POINTS-1.
  - All outputs are flop-driven; out_data passes through only a mux.
  - Advance rd_cnt on out_valid && out_ready.
  - On the handshake at rd_cnt==NUM_POINTS-1: clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0.
  - out_data and out_index hold stable while out_valid && !out_ready.
- Latency and throughput:
  - The first output of a frame is valid in the cycle after the edge that accepted that frame's last input.
  - Sustained 1 sample/cycle when out_ready is held high.
- Boundaries:
  - Both banks full: in_ready=0 until the reader releases a bank.
  - Reader releasing bank A on the same edge the writer fills bank B: both flag updates take effect on that edge.
  - The writer never writes a full bank, and the reader never reads a non-full bank.
  - in_data is ignored when in_valid=0 or in_ready=0.

Decomposition:
- Package fft_pkg:
  - Localparams NUM_POINTS_DEFAULT and DATA_WIDTH_DEFAULT.
  - A bitrev function parametrised by width (a generic loop reversing IDX_WIDTH bits).
  - A typedef for the complex sample (struct of signed I and Q, DATA_WIDTH/2 each).
- Sub-module reorder_bank: one storage bank with write port (we, waddr, wdata), combinational read port (raddr, rdata), full flag set/clear, and mode bit. Instantiated twice.
- Control counters stay in the top module.

Test Plan (N=8, DATA_WIDTH=16, data = sample index):
1. Hold reset=0 for 2 cycles -> in_ready=1, out_valid=0, out_last=0, out_index=0.
2. Push 0..7 with in_reverse=1 and out_ready=1 -> out_valid rises the cycle after sample 7 is accepted; out_data = 0,4,2,6,1,5,3,7; out_index = 0..7; out_last only with data 7.
3. Push 0..7 with in_reverse=0 -> out_data = 0..7 in order; then push a frame with in_reverse=1 and toggle in_reverse mid-frame -> that frame's output is still bit-reversed.
4. out_ready=0 and push 0..15 continuously -> in_ready=0 after the 16th accept and the 17th sample stalls. Then out_ready=1 -> 0,4,2,6,1,5,3,7 followed by 8,12,10,14,9,13,11,15, and in_ready returns to 1 the cycle after the first frame drains.
5. Continuous in_valid=1 and out_ready=1 for 4 frames -> no bubbles after initial latency, 32 outputs in 32 consecutive cycles, including the same-edge fill/release case.
6. Accept 5 samples, pulse reset=0 for 1 cycle, then push a full frame 0..7 with in_reverse=1 -> out_valid=0 until the new frame completes, then 0,4,2,6,1,5,3,7.
